// File: rtl/traffic_pkg.sv
// traffic_pkg: shared mode codes and helpers for the traffic mode arbiter.
//   MODE_DAY / MODE_NIGHT : base mode codes (0 / 1)
//   REQ_BASE              : mode code of request 0; request i maps to REQ_BASE+i
//   req_mode(i)           : mode code for request index i
//   mode_rank(mode)       : priority rank (DAY/NIGHT = 0, REQ_i = i+1)
package traffic_pkg;

  localparam int MODE_DAY   = 0;
  localparam int MODE_NIGHT = 1;
  localparam int REQ_BASE   = 2;

  function automatic int req_mode(input int i);
    return REQ_BASE + i;
  endfunction

  // DAY and NIGHT share the lowest rank, so a DAY<->NIGHT swap is never a
  // preemption and always waits for the dwell timer.
  function automatic int mode_rank(input int mode);
    return (mode < REQ_BASE) ? 0 : (mode - REQ_BASE + 1);
  endfunction

endpackage

// File: rtl/traffic_sync.sv
// traffic_sync: W-bit two-flop synchroniser for asynchronous level inputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_d        : asynchronous input vector
//   o_q        : synchronised output vector (two-edge latency)
// RST_VAL is the value every bit of both flop stages takes in reset.
module traffic_sync #(
  parameter int   W       = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= {W{RST_VAL}};
      r_sync <= {W{RST_VAL}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/traffic_mode_arbiter.sv
// traffic_mode_arbiter: chooses the light-sequencer mode from the debounced
// day/night input and NUM_REQ prioritised, sticky request inputs.
//   clk, rst_n   : clock, asynchronous active-low reset
//   day_night    : 1 = day, 0 = night (asynchronous)
//   req          : request levels, req[NUM_REQ-1] highest priority (asynchronous)
//   served       : one-cycle pulse from the sequencer, current request mode done
//   current_mode : DAY=0, NIGHT=1, REQ_i=2+i (this register is the mode FSM state)
//   mode_change  : high in the first cycle of a new mode
//   pending      : latched request flags
//   dwell_done   : dwell counter has reached MIN_DWELL-1; downgrades allowed
module traffic_mode_arbiter
  import traffic_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int MIN_DWELL = 16,
  parameter  int DEBOUNCE  = 4,
  localparam int MODE_W    = $clog2(NUM_REQ + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               day_night,
  input  logic [NUM_REQ-1:0] req,
  input  logic               served,
  output logic [MODE_W-1:0]  current_mode,
  output logic               mode_change,
  output logic [NUM_REQ-1:0] pending,
  output logic               dwell_done
);

  localparam int DW_W  = $clog2(MIN_DWELL);
  localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(MIN_DWELL - 1);
  localparam logic [DEB_W-1:0] DEB_MAX   = DEB_W'(DEBOUNCE - 1);

  // ---------------------------------------------------------------- sync
  logic               w_dn_s;
  logic [NUM_REQ-1:0] w_req_s;

  traffic_sync #(.W(1), .RST_VAL(1'b1)) u_sync_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (day_night),
    .o_q   (w_dn_s)
  );

  traffic_sync #(.W(NUM_REQ), .RST_VAL(1'b0)) u_sync_req (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (req),
    .o_q   (w_req_s)
  );

  // ------------------------------------------------------------ debounce
  logic             r_day_flag;
  logic [DEB_W-1:0] r_deb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_day_flag <= 1'b1;
      r_deb_cnt  <= '0;
    end else if (w_dn_s != r_day_flag) begin
      if (r_deb_cnt == DEB_MAX) begin
        r_day_flag <= w_dn_s;
        r_deb_cnt  <= '0;
      end else begin
        r_deb_cnt  <= r_deb_cnt + 1'b1;
      end
    end else begin
      r_deb_cnt <= '0;
    end
  end

  // ------------------------------------------------------ request latches
  logic [MODE_W-1:0]  r_mode;
  logic [NUM_REQ-1:0] r_pending;
  logic [NUM_REQ-1:0] w_clr;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_clr[i] = served && (r_mode == MODE_W'(req_mode(i)));
    end
  end

  // A live request in the same cycle as its clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_req_s | (r_pending & ~w_clr);
    end
  end

  // ---------------------------------------------------------- target mode
  logic [MODE_W-1:0] w_target;

  always_comb begin
    w_target = r_day_flag ? MODE_W'(MODE_DAY) : MODE_W'(MODE_NIGHT);
    // Ascending scan: the highest set index is written last and wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_pending[i]) begin
        w_target = MODE_W'(req_mode(i));
      end
    end
  end

  // ---------------------------------------------------- mode FSM + dwell
  logic [DW_W-1:0]   r_dwell_cnt;
  logic              r_dwell_done;
  logic              r_mode_change;
  logic [MODE_W-1:0] w_mode_nxt;
  logic              w_change;
  logic [DW_W-1:0]   w_dwell_nxt;

  always_comb begin
    w_mode_nxt  = r_mode;
    w_change    = 1'b0;
    w_dwell_nxt = r_dwell_cnt;
    // Higher rank preempts immediately; anything else waits for dwell.
    if ((w_target != r_mode) &&
        ((mode_rank(int'(w_target)) > mode_rank(int'(r_mode))) || r_dwell_done)) begin
      w_change   = 1'b1;
      w_mode_nxt = w_target;
    end
    if (w_change) begin
      w_dwell_nxt = '0;
    end else if (r_dwell_cnt != DWELL_MAX) begin
      w_dwell_nxt = r_dwell_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= MODE_W'(MODE_DAY);
      r_mode_change <= 1'b0;
      r_dwell_cnt   <= '0;
      r_dwell_done  <= 1'b0;
    end else begin
      r_mode        <= w_mode_nxt;
      r_mode_change <= w_change;
      r_dwell_cnt   <= w_dwell_nxt;
      r_dwell_done  <= (w_dwell_nxt == DWELL_MAX);
    end
  end

  assign current_mode = r_mode;
  assign mode_change  = r_mode_change;
  assign pending      = r_pending;
  assign dwell_done   = r_dwell_done;

endmodule

// File: tb/tb_traffic_mode_arbiter.sv
// Directed bench for traffic_mode_arbiter with NUM_REQ=2, MIN_DWELL=16,
// DEBOUNCE=4. Expected values are hand-derived from the edge latencies:
// request -> pending after 3 edges, -> mode after 4; day/night flag flips at
// edge 2+DEBOUNCE; a downgrade needs MIN_DWELL edges from mode entry.
module tb_traffic_mode_arbiter;

  logic       clk;
  logic       rst_n;
  logic       day_night;
  logic [1:0] req;
  logic       served;
  logic [1:0] current_mode;
  logic       mode_change;
  logic [1:0] pending;
  logic       dwell_done;

  int n_vec;
  int n_err;

  traffic_mode_arbiter #(
    .NUM_REQ   (2),
    .MIN_DWELL (16),
    .DEBOUNCE  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .day_night    (day_night),
    .req          (req),
    .served       (served),
    .current_mode (current_mode),
    .mode_change  (mode_change),
    .pending      (pending),
    .dwell_done   (dwell_done)
  );

  // ------------------------------------------------------ clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; outputs are sampled and inputs driven 1ns later.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0; day_night = 1'b1; req = 2'b00; served = 1'b0;
    #23;
    n_vec++; if (current_mode !== 2'd0) begin n_err++; $display("FAIL reset_mode got %0d want 0", current_mode); end
    n_vec++; if (pending !== 2'b00) begin n_err++; $display("FAIL reset_pending got %b want 00", pending); end
    n_vec++; if (mode_change !== 1'b0) begin n_err++; $display("FAIL reset_change got %b want 0", mode_change); end
    n_vec++; if (dwell_done !== 1'b0) begin n_err++; $display("FAIL reset_dwell got %b want 0", dwell_done); end
    tick(1);
    rst_n = 1'b1;
    tick(14);
    n_vec++; if (dwell_done !== 1'b0) begin n_err++; $display("FAIL dwell_early got %b want 0", dwell_done); end
    tick(1);
    n_vec++; if (dwell_done !== 1'b1) begin n_err++; $display("FAIL dwell_15 got %b want 1", dwell_done); end
    n_vec++; if (current_mode !== 2'd0) begin n_err++; $display("FAIL idle_mode got %0d want 0", current_mode); end
  endtask

  task automatic test_pedestrian();
    req = 2'b01;
    tick(1);
    req = 2'b00;
    tick(2);
    n_vec++; if (pending !== 2'b01) begin n_err++; $display("FAIL ped_pending got %b want 01", pending); end
    n_vec++; if (current_mode !== 2'd0) begin n_err++; $display("FAIL ped_mode_e3 got %0d want 0", current_mode); end
    tick(1);
    n_vec++; if (current_mode !== 2'd2) begin n_err++; $display("FAIL ped_mode_e4 got %0d want 2", current_mode); end
    n_vec++; if (mode_change !== 1'b1) begin n_err++; $display("FAIL ped_change got %b want 1", mode_change); end
    tick(14);
    n_vec++; if (dwell_done !== 1'b0) begin n_err++; $display("FAIL ped_dwell14 got %b want 0", dwell_done); end
    tick(1);
    n_vec++; if (dwell_done !== 1'b1) begin n_err++; $display("FAIL ped_dwell15 got %b want 1", dwell_done); end
    served = 1'b1;
    tick(1);
    served = 1'b0;
    n_vec++; if (pending !== 2'b00) begin n_err++; $display("FAIL ped_clear got %b want 00", pending); end
    n_vec++; if (current_mode !== 2'd2) begin n_err++; $display("FAIL ped_hold got %0d want 2", current_mode); end
    tick(1);
    n_vec++; if (current_mode !== 2'd0) begin n_err++; $display("FAIL ped_down got %0d want 0", current_mode); end
    n_vec++; if (mode_change !== 1'b1) begin n_err++; $display("FAIL ped_down_change got %b want 1", mode_change); end
  endtask

  task automatic test_preemption();
    // Mode 0 was just entered, so dwell is not done; rank-up still preempts.
    req = 2'b01;
    tick(1);
    req = 2'b00;
    tick(3);
    n_vec++; if (current_mode !== 2'd2) begin n_err++; $display("FAIL pre_ped got %0d want 2", current_mode); end
    tick(3);
    req = 2'b10;
    tick(1);
    req = 2'b00;
    tick(2);
    n_vec++; if (pending !== 2'b11) begin n_err++; $display("FAIL pre_pending got %b want 11", pending); end
    n_vec++; if (current_mode !== 2'd2) begin n_err++; $display("FAIL pre_mode_e3 got %0d want 2", current_mode); end
    tick(1);
    n_vec++; if (current_mode !== 2'd3) begin n_err++; $display("FAIL pre_emg got %0d want 3", current_mode); end
    n_vec++; if (mode_change !== 1'b1) begin n_err++; $display("FAIL pre_change got %b want 1", mode_change); end
    served = 1'b1;
    tick(1);
    served = 1'b0;
    n_vec++; if (pending !== 2'b01) begin n_err++; $display("FAIL pre_served got %b want 01", pending); end
    tick(13);
    n_vec++; if (current_mode !== 2'd3) begin n_err++; $display("FAIL pre_hold14 got %0d want 3", current_mode); end
    n_vec++; if (dwell_done !== 1'b0) begin n_err++; $display("FAIL pre_dwell14 got %b want 0", dwell_done); end
    tick(1);
    n_vec++; if (current_mode !== 2'd3) begin n_err++; $display("FAIL pre_hold15 got %0d want 3", current_mode); end
    n_vec++; if (dwell_done !== 1'b1) begin n_err++; $display("FAIL pre_dwell15 got %b want 1", dwell_done); end
    tick(1);
    n_vec++; if (current_mode !== 2'd2) begin n_err++; $display("FAIL pre_drop got %0d want 2", current_mode); end
    n_vec++; if (pending !== 2'b01) begin n_err++; $display("FAIL pre_keep got %b want 01", pending); end
    tick(15);
    served = 1'b1;
    tick(1);
    served = 1'b0;
    n_vec++; if (pending !== 2'b00) begin n_err++; $display("FAIL pre_ped_clear got %b want 00", pending); end
    tick(1);
    n_vec++; if (current_mode !== 2'd0) begin n_err++; $display("FAIL pre_day got %0d want 0", current_mode); end
  endtask

  task automatic test_debounce();
    tick(16);
    day_night = 1'b0;
    tick(3);
    day_night = 1'b1;
    tick(12);
    n_vec++; if (current_mode !== 2'd0) begin n_err++; $display("FAIL deb_glitch got %0d want 0", current_mode); end
    n_vec++; if (mode_change !== 1'b0) begin n_err++; $display("FAIL deb_glitch_chg got %b want 0", mode_change); end
    day_night = 1'b0;
    tick(6);
    n_vec++; if (current_mode !== 2'd0) begin n_err++; $display("FAIL deb_e6 got %0d want 0", current_mode); end
    tick(1);
    n_vec++; if (current_mode !== 2'd1) begin n_err++; $display("FAIL deb_night got %0d want 1", current_mode); end
    n_vec++; if (mode_change !== 1'b1) begin n_err++; $display("FAIL deb_night_chg got %b want 1", mode_change); end
    // Back to day: flag flips after 6 edges but the swap waits for dwell.
    day_night = 1'b1;
    tick(15);
    n_vec++; if (current_mode !== 2'd1) begin n_err++; $display("FAIL deb_dwell got %0d want 1", current_mode); end
    tick(1);
    n_vec++; if (current_mode !== 2'd0) begin n_err++; $display("FAIL deb_day got %0d want 0", current_mode); end
  endtask

  task automatic test_collision();
    req = 2'b01;
    tick(4);
    n_vec++; if (current_mode !== 2'd2) begin n_err++; $display("FAIL col_enter got %0d want 2", current_mode); end
    tick(15);
    n_vec++; if (dwell_done !== 1'b1) begin n_err++; $display("FAIL col_dwell got %b want 1", dwell_done); end
    served = 1'b1;
    tick(1);
    served = 1'b0;
    n_vec++; if (pending !== 2'b01) begin n_err++; $display("FAIL col_set_wins got %b want 01", pending); end
    tick(1);
    n_vec++; if (current_mode !== 2'd2) begin n_err++; $display("FAIL col_stay got %0d want 2", current_mode); end
    n_vec++; if (mode_change !== 1'b0) begin n_err++; $display("FAIL col_stay_chg got %b want 0", mode_change); end
    req = 2'b00;
    tick(3);
    served = 1'b1;
    tick(1);
    served = 1'b0;
    n_vec++; if (pending !== 2'b00) begin n_err++; $display("FAIL col_clear got %b want 00", pending); end
    tick(1);
    n_vec++; if (current_mode !== 2'd0) begin n_err++; $display("FAIL col_day got %0d want 0", current_mode); end
  endtask

  task automatic test_saturation();
    tick(16);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      n_vec++; if (dwell_done !== 1'b1) begin n_err++; $display("FAIL sat_dwell cyc %0d got %b want 1", i, dwell_done); end
      n_vec++; if (mode_change !== 1'b0) begin n_err++; $display("FAIL sat_change cyc %0d got %b want 0", i, mode_change); end
      n_vec++; if (current_mode !== 2'd0) begin n_err++; $display("FAIL sat_mode cyc %0d got %0d want 0", i, current_mode); end
    end
  endtask

  task automatic test_async_reset();
    req = 2'b10;
    tick(1);
    req = 2'b00;
    tick(3);
    n_vec++; if (current_mode !== 2'd3) begin n_err++; $display("FAIL ar_emg got %0d want 3", current_mode); end
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++; if (current_mode !== 2'd0) begin n_err++; $display("FAIL ar_mode got %0d want 0", current_mode); end
    n_vec++; if (pending !== 2'b00) begin n_err++; $display("FAIL ar_pending got %b want 00", pending); end
    n_vec++; if (mode_change !== 1'b0) begin n_err++; $display("FAIL ar_change got %b want 0", mode_change); end
    n_vec++; if (dwell_done !== 1'b0) begin n_err++; $display("FAIL ar_dwell got %b want 0", dwell_done); end
    #2;
    rst_n = 1'b1;
    tick(5);
    n_vec++; if (current_mode !== 2'd0) begin n_err++; $display("FAIL ar_discard got %0d want 0", current_mode); end
    n_vec++; if (pending !== 2'b00) begin n_err++; $display("FAIL ar_discard_pend got %b want 00", pending); end
  endtask

  // -------------------------------------------------------------- sequence
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_pedestrian();
    test_preemption();
    test_debounce();
    test_collision();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_mode_arbiter.md
# traffic_mode_arbiter

Parametrised successor to the two-bit traffic mode register. It arbitrates between the base day/night mode and `NUM_REQ` prioritised request inputs, with request order fixed: pedestrian lowest, emergency highest. Over the single-register design it adds:
- input synchronisation and day/night debounce;
- sticky request latching until the downstream phase sequencer reports the request served;
- a minimum-dwell timer that blocks downgrades but never blocks preemption.

The block sits between the sensor inputs and the light phase sequencer. Its `current_mode` output drives the sequencer.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of request inputs. `req[0]` is the lowest priority; `req[NUM_REQ-1]` is the highest (emergency).
- `MIN_DWELL`, default 16: minimum cycles in a mode before any downgrade. Must be ≥ 2.
- `DEBOUNCE`, default 4: consecutive stable cycles required before the day/night flag flips. Must be ≥ 1.
- `MODE_W`, derived localparam = `$clog2(NUM_REQ+2)`: mode width.

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `day_night`  in  1  1 = day, 0 = night; asynchronous
- `req`  in  `NUM_REQ`  request levels; asynchronous
- `served`  in  1  one-cycle pulse from the sequencer, synchronous to `clk`: the current request mode has completed
- `current_mode`  out  `MODE_W`  DAY=0, NIGHT=1, REQ_i=2+i. With `NUM_REQ`=2 this gives ped=2, emg=3.
- `mode_change`  out  1  one-cycle pulse, high in the first cycle of a new mode
- `pending`  out  `NUM_REQ`  latched request flags
- `dwell_done`  out  1  high when the dwell counter has reached `MIN_DWELL`-1

## Operation
Synchronisation:
- `day_night` and each `req` bit pass through a 2-flop synchroniser.
- The `day_night` synchroniser resets to 1; all other synchroniser flops reset to 0.
- `served` is not synchronised.

Day/night debounce:
- `day_flag` resets to 1.
- While the synchronised `day_night` differs from `day_flag`, `deb_cnt` increments. When they are equal, `deb_cnt` clears to 0.
- When `deb_cnt` = `DEBOUNCE`-1 and the inputs still differ, `day_flag` toggles on the next edge and `deb_cnt` clears.

Request latching:
- `pending[i]` sets while synchronised `req[i]` = 1.
- `pending[i]` clears on a cycle where `served`=1 and `current_mode`==2+i.
- If set and clear occur in the same cycle, set wins.
- `served` in DAY or NIGHT mode is ignored.

Target mode:
- If any `pending` bit is set, target = 2 + the highest set index.
- Otherwise, target = `day_flag` ? DAY : NIGHT.

Mode register (transitions happen only when target ≠ `current_mode`):
- Priority rank: DAY and NIGHT share the lowest rank; REQ_i has rank i+1.
- Preemption: a target of higher rank than the current mode is taken on the next edge, regardless of the dwell counter.
- Otherwise (equal or lower rank, including DAY↔NIGHT): the mode changes only when `dwell_done`=1.
- A preempted lower request stays pending and is served later.

Dwell counter:
- Width `$clog2(MIN_DWELL)`.
- Clears to 0 on every mode change; otherwise increments and saturates at `MIN_DWELL`-1.

Reset (`rst_n`=0, asynchronous, takes effect without a clock edge):
- `current_mode`=0, `pending`=0, `mode_change`=0, `dwell_done`=0.
- All counters = 0; `day_flag`=1.
- A reset mid-request discards the request.

## Timing
- Request latency: `req` is high before edge 1. The synchroniser output is valid after edge 2, `pending` after edge 3, and `current_mode` after edge 4 (preemption, or dwell already done).
- `mode_change` is registered and asserts in the same cycle as the new `current_mode`.
- Day/night latency: the input changes before edge 1. `day_flag` flips at edge 2+`DEBOUNCE`; the mode changes one edge later if dwell is done.
- `dwell_done` is registered. After a change it first asserts `MIN_DWELL`-1 cycles later, so the earliest downgrade occurs `MIN_DWELL` cycles after entry.
- `served`→`pending` clear takes 1 edge; the mode downgrade follows one edge later if dwell is done.

## Structure
- `traffic_pkg` holds:
  - the `MODE_DAY` and `MODE_NIGHT` constants;
  - `REQ_BASE`=2;
  - a function `req_mode(i)` returning the mode code for request i;
  - a function `mode_rank(mode)` returning its priority rank.
- Sub-module `traffic_sync`: a 2-flop synchroniser with a reset-value parameter, instantiated once for `day_night` and once for the `req` vector.

## Test plan
- Reset: drive `rst_n`=0 asynchronously mid-cycle while in mode 3 → outputs go to `current_mode`=0, `pending`=0, `mode_change`=0 immediately, with no clock edge.
- Pedestrian: after dwell is done, a 1-cycle `req[0]` pulse → `pending`=01 after edge 3, `current_mode`=2 with `mode_change`=1 after edge 4. Then `served` → `pending`=00 next edge, `current_mode`=0 one edge later.
- Preemption: in mode 2 with dwell count 3 (`MIN_DWELL`=16), `req[1]` rises → mode 3 at +4 edges while `pending[0]` stays 1. After emergency is served, mode 3 is held until 16 cycles from entry, then drops to 2.
- Debounce (`DEBOUNCE`=4): a 3-cycle low glitch on `day_night` → `day_flag` and mode unchanged. A low lasting ≥4 cycles → mode 1 after flag flip + dwell.
- Set/clear collision: `req[0]` held high while `served` pulses in mode 2 → `pending[0]` remains 1 and the mode stays 2.
- Saturation: remain in DAY for 100 cycles → `dwell_done` stays 1, the counter holds at 15, and `mode_change` stays 0.
